rib_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits as a responder on the RIB bus behind the processor core's load/store port. The core's execute stage writes bytes into an internal FIFO through register accesses; a serialiser drains the FIFO onto `tx_o` as 8N1 frames. When the core writes while the FIFO is full, the block asserts a bus hold. The bus interconnect feeds that hold into the core's hold-flag input, stalling the pipeline until space frees.

---
 rtl/rib_uart_tx_pkg.sv | 23 ++
 rtl/rib_uart_tx_sync_fifo.sv | 59 +++++
 rtl/rib_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_rib_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rib_uart_tx_pkg.sv
// Shared constants for the RIB UART transmitter: register offsets, FSM states,
// and the minimum bit-period divisor.
package rib_uart_tx_pkg;

    localparam logic [1:0] UART_CTRL   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_TXDATA = 2'd3;

    localparam logic [15:0] UART_MIN_DIV = 16'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] eff_period(input logic [15:0] baud);
        return (baud < UART_MIN_DIV) ? UART_MIN_DIV : baud;
    endfunction

endpackage

// File: rtl/rib_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rib_uart_tx.sv
// RIB-bus UART transmitter: register file, TX FIFO and 8N1 serialiser.
// A TXDATA write into a full FIFO holds the bus while transmission is enabled.
module rib_uart_tx
    import rib_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST   = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hold_o,
    output logic        tx_o,
    output logic        int_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          tx_en_q, tx_en_d, int_en_q, int_en_d, ovf_q, ovf_d;
    logic [15:0]   baud_q, baud_d;
    tx_state_e     state_q, state_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d, period_q, period_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;

    logic          wr_en, txdata_wr, push, pop, cnt_done, busy;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

    assign wr_en     = req_i & we_i;
    assign txdata_wr = wr_en & (addr_i[3:2] == UART_TXDATA);
    // A pop in the same cycle does not free space for a blocked push; it lands next edge.
    assign push      = txdata_wr & ~fifo_full;
    assign hold_o    = txdata_wr & fifo_full & tx_en_q;
    assign int_o     = int_en_q & fifo_empty & (state_q == IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (data_i[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        tx_en_d  = tx_en_q;
        int_en_d = int_en_q;
        baud_d   = baud_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            case (addr_i[3:2])
                UART_CTRL: begin
                    tx_en_d  = data_i[0];
                    int_en_d = data_i[1];
                end
                UART_STATUS: if (data_i[3]) ovf_d = 1'b0;
                UART_BAUD:   baud_d = data_i[15:0];
                default:     if (fifo_full && !tx_en_q) ovf_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_en_q  <= 1'b0;
            int_en_q <= 1'b0;
            baud_q   <= BAUD_RST;
            ovf_q    <= 1'b0;
        end else begin
            tx_en_q  <= tx_en_d;
            int_en_q <= int_en_d;
            baud_q   <= baud_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        data_o = '0;
        if (req_i) begin
            case (addr_i[3:2])
                UART_CTRL:   data_o = {30'd0, int_en_q, tx_en_q};
                UART_STATUS: data_o = {20'd0, 4'(fifo_count), 4'd0,
                                       ovf_q, busy, fifo_empty, fifo_full};
                UART_BAUD:   data_o = {16'd0, baud_q};
                default:     data_o = '0;
            endcase
        end
    end

    assign cnt_done = (baud_cnt_q == period_q - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            period_q   <= UART_MIN_DIV;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            period_q   <= period_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        period_d   = period_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (tx_en_q && !fifo_empty) begin
                    pop      = 1'b1;
                    state_d  = START;
                    shreg_d  = fifo_rdata;
                    period_d = eff_period(baud_q);
                end
            end
            START: if (cnt_done) begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = DATA;
            end
            DATA: if (cnt_done) begin
                baud_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_done) begin
                baud_cnt_d = '0;
                if (tx_en_q && !fifo_empty) begin
                    pop      = 1'b1;
                    state_d  = START;
                    shreg_d  = fifo_rdata;
                    period_d = eff_period(baud_q);
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        busy = (state_q != IDLE);
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shreg_q[bit_cnt_q];
            default: tx_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_rib_uart_tx.sv
// Directed bench for rib_uart_tx: register access, frame timing, hold and overflow.
module tb_rib_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        hold_o, tx_o, int_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_BAUD = 2'd2, A_TXDATA = 2'd3;

    always #5 clk = ~clk;

    rib_uart_tx #(
        .FIFO_DEPTH (8),
        .BAUD_RST   (16'd434)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .hold_o (hold_o),
        .tx_o   (tx_o),
        .int_o  (int_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a write at a negedge and keeps it stable until hold_o drops.
    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int hold_cycles);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, a, 2'b00}; data_i = d;
        hold_cycles = 0;
        #1;
        while (hold_o === 1'b1 && hold_cycles < 2000) begin
            hold_cycles++;
            @(negedge clk);
            #1;
        end
        if (hold_cycles >= 2000) chk("hold_timeout", {31'd0, hold_o}, 32'd0);
        @(posedge clk);
        #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wrs(input logic [1:0] a, input logic [31:0] d);
        int hc;
        wr(a, d, hc);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, a, 2'b00};
        #1;
        d = data_o;
        req_i = 1'b0;
    endtask

    // Finds the start bit and samples each bit mid-cell; returns at the stop-bit centre.
    task automatic rx_frame(input logic [7:0] b, input int p, input string tag);
        int w = 0;
        @(negedge clk);
        while (tx_o !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_start_seen"}, {31'd0, tx_o}, 32'd0);
        repeat (p / 2) @(negedge clk);
        chk({tag, "_start"}, {31'd0, tx_o}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (p) @(negedge clk);
            chk({tag, "_bit"}, {31'd0, tx_o}, {31'd0, b[k]});
        end
        repeat (p) @(negedge clk);
        chk({tag, "_stop"}, {31'd0, tx_o}, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  a5;
        logic        exp_tx;
        int          hc;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_tx", {31'd0, tx_o}, 32'd1);
        chk("rst_hold", {31'd0, hold_o}, 32'd0);
        chk("rst_int", {31'd0, int_o}, 32'd0);
        chk("rst_dout_noreq", data_o, 32'd0);
        rd(A_STATUS, r); chk("rst_status", r, 32'h0000_0002);
        rd(A_BAUD, r);   chk("rst_baud", r, 32'd434);
        rd(A_CTRL, r);   chk("rst_ctrl", r, 32'd0);

        // Single byte with exact frame timing
        wrs(A_BAUD, 32'd16);
        wrs(A_CTRL, 32'd1);
        @(negedge clk); chk("int_disabled", {31'd0, int_o}, 32'd0);
        wrs(A_CTRL, 32'd3);
        @(negedge clk); chk("int_idle_empty", {31'd0, int_o}, 32'd1);
        rd(A_CTRL, r);  chk("ctrl_rb", r, 32'd3);
        rd(A_TXDATA, r); chk("txdata_rd_zero", r, 32'd0);
        wrs(A_TXDATA, 32'h0000_00A5);
        @(negedge clk); chk("sb_pre_fall", {31'd0, tx_o}, 32'd1);
        a5 = 8'hA5;
        for (int i = 0; i <= 160; i++) begin
            @(negedge clk);
            if (i < 16)       exp_tx = 1'b0;
            else if (i < 144) exp_tx = a5[(i - 16) / 16];
            else              exp_tx = 1'b1;
            chk("sb_tx", {31'd0, tx_o}, {31'd0, exp_tx});
            if (i == 5)   chk("sb_int_busy", {31'd0, int_o}, 32'd0);
            if (i == 159) begin rd(A_STATUS, r); chk("sb_busy_last", {29'd0, r[2:0]}, 32'd6); end
            if (i == 160) begin
                rd(A_STATUS, r); chk("sb_busy_clear", r, 32'h0000_0002);
                chk("sb_int_done", {31'd0, int_o}, 32'd1);
            end
        end

        // Back-to-back frames
        wrs(A_CTRL, 32'd1);
        wrs(A_TXDATA, 32'h55);
        wrs(A_TXDATA, 32'h0F);
        rx_frame(8'h55, 16, "b2b0");
        repeat (7) @(negedge clk);
        chk("b2b_stop_end", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        chk("b2b_no_gap", {31'd0, tx_o}, 32'd0);
        rx_frame(8'h0F, 16, "b2b1");
        repeat (170) @(negedge clk);
        rd(A_STATUS, r); chk("b2b_idle", r, 32'h0000_0002);

        // FIFO full with bus hold
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    wr(A_TXDATA, 32'h10 + i, hc);
                    chk("full_hold_cycles", hc, (i == 9) ? 32'd153 : 32'd0);
                end
            end
            begin
                for (int i = 0; i < 10; i++) rx_frame(8'(8'h10 + i), 16, "full");
            end
        join
        repeat (200) @(negedge clk);
        rd(A_STATUS, r); chk("full_drained", r, 32'h0000_0002);

        // Overflow with transmit disabled
        wrs(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) begin
            wr(A_TXDATA, 32'h40 + i, hc);
            chk("ovf_no_hold", hc, 32'd0);
        end
        @(negedge clk);
        rd(A_STATUS, r); chk("ovf_status", r, 32'h0000_0809);
        wrs(A_STATUS, 32'h8);
        @(negedge clk);
        rd(A_STATUS, r); chk("ovf_cleared", r, 32'h0000_0801);

        // BAUD change mid-frame applies to the next frame only
        wrs(A_CTRL, 32'd1);
        fork
            rx_frame(8'h40, 16, "bd16");
            begin
                repeat (60) @(negedge clk);
                wrs(A_BAUD, 32'd32);
            end
        join
        rx_frame(8'h41, 32, "bd32");
        rd(A_BAUD, r); chk("bd_rb", r, 32'd32);

        // Reset during DATA aborts the frame
        hc = 0;
        while (tx_o !== 1'b0 && hc < 3000) begin @(negedge clk); hc++; end
        chk("rst_mid_start_seen", {31'd0, tx_o}, 32'd0);
        repeat (72) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_tx", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rd(A_STATUS, r); chk("rst_mid_status", r, 32'h0000_0002);
        rd(A_BAUD, r);   chk("rst_mid_baud", r, 32'd434);
        repeat (40) @(negedge clk);
        chk("rst_mid_idle_tx", {31'd0, tx_o}, 32'd1);

        // Divisor below the minimum is clamped to 16
        wrs(A_BAUD, 32'd4);
        wrs(A_CTRL, 32'd1);
        wrs(A_TXDATA, 32'h3C);
        rx_frame(8'h3C, 16, "clamp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
